mem_buffer_walker: RTL and testbench

// Consumes one buffer descriptor (vaddr, size) per stream, as produced by the host-written memory

---
 rtl/mem_buffer_walker_pkg.sv | 28 ++
 rtl/mem_buffer_walker_inflight.sv | 43 ++++
 rtl/mem_buffer_walker.sv | 145 ++++++++++++++
 tb/tb_mem_buffer_walker.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_buffer_walker_pkg.sv
// Shared types for the buffer walker and neighbouring DMA stages.
// Widths here are the default build; the walker itself is parameterised.
package mem_buffer_walker_pkg;

   localparam int VADDR_BITS_DEF      = 48;
   localparam int SIZE_BITS_DEF       = 28;
   localparam int MAX_REQ_BYTES_DEF   = 4096;
   localparam int MAX_OUTSTANDING_DEF = 8;
   localparam int LEN_BITS_DEF        = $clog2(MAX_REQ_BYTES_DEF) + 1;

   typedef logic [VADDR_BITS_DEF-1:0] vaddress_t;
   typedef logic [SIZE_BITS_DEF-1:0]  alloc_size_t;
   typedef logic [LEN_BITS_DEF-1:0]   mem_req_len_t;

   typedef struct packed {
      vaddress_t    vaddr;
      mem_req_len_t len;
      logic         last;
   } mem_req_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SPLIT = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } walker_state_e;

endpackage

// File: rtl/mem_buffer_walker_inflight.sv
// Up/down counter of issued-but-uncompleted requests with limit compare and
// sticky underflow flag; a completion with nothing in flight is dropped.
module inflight_counter #(
   parameter int  LIMIT = 8,
   localparam int CW    = $clog2(LIMIT + 1)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_inc,
   input  logic          i_dec,
   output logic [CW-1:0] o_count_nxt,
   output logic          o_below_limit_nxt,
   output logic          o_err_underflow
);

   logic [CW-1:0] r_count;
   logic          r_err;
   logic          w_underflow;

   always_comb begin
      w_underflow = i_dec && !i_inc && (r_count == '0);
      o_count_nxt = r_count;
      if (i_inc && !i_dec)
         o_count_nxt = r_count + CW'(1);
      else if (i_dec && !i_inc && !w_underflow)
         o_count_nxt = r_count - CW'(1);
   end

   assign o_below_limit_nxt = (o_count_nxt < CW'(LIMIT));
   assign o_err_underflow   = r_err;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_count <= '0;
         r_err   <= 1'b0;
      end else begin
         r_count <= o_count_nxt;
         if (w_underflow)
            r_err <= 1'b1;
      end
   end

endmodule

// File: rtl/mem_buffer_walker.sv
// Buffer descriptor walker: splits (vaddr, size) into requests that never cross
// a MAX_REQ_BYTES boundary, bounds requests in flight, pulses done at the end.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ready for a descriptor
// ST_SPLIT | issuing requests, stalled while the in-flight limit is hit
// ST_DRAIN | all requests issued, waiting for outstanding completions
// ST_DONE  | one-cycle done pulse, then back to idle
module mem_buffer_walker
   import mem_buffer_walker_pkg::*;
#(
   parameter int  VADDR_BITS      = VADDR_BITS_DEF,
   parameter int  SIZE_BITS       = SIZE_BITS_DEF,
   parameter int  MAX_REQ_BYTES   = MAX_REQ_BYTES_DEF,
   parameter int  MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
   localparam int LEN_BITS        = $clog2(MAX_REQ_BYTES) + 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [VADDR_BITS-1:0] i_buf_vaddr,
   input  logic [SIZE_BITS-1:0]  i_buf_size,
   input  logic                  i_buf_valid,
   output logic                  o_buf_ready,
   output logic [VADDR_BITS-1:0] o_req_vaddr,
   output logic [LEN_BITS-1:0]   o_req_len,
   output logic                  o_req_last,
   output logic                  o_req_valid,
   input  logic                  i_req_ready,
   input  logic                  i_cpl_valid,
   output logic                  o_done_valid,
   output logic                  o_busy,
   output logic                  o_err_cpl
);

   localparam int CNT_BITS = $clog2(MAX_OUTSTANDING + 1);

   walker_state_e         r_state, w_state_nxt;
   logic [VADDR_BITS-1:0] r_addr, w_addr_nxt;
   logic [SIZE_BITS-1:0]  r_rem, w_rem_nxt;
   logic [VADDR_BITS-1:0] r_req_vaddr;
   logic [LEN_BITS-1:0]   r_req_len;
   logic                  r_req_last;
   logic                  r_req_valid;
   logic                  r_ready_en;
   logic                  w_accept;
   logic                  w_issue;
   logic [LEN_BITS-1:0]   w_room;
   logic [LEN_BITS-1:0]   w_split_len;
   logic                  w_split_last;
   logic [CNT_BITS-1:0]   w_cnt_nxt;
   logic                  w_below_nxt;

   assign w_accept = (r_state == ST_IDLE) && r_ready_en && i_buf_valid;
   assign w_issue  = r_req_valid && i_req_ready;

   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_addr_nxt  = r_addr;
      w_rem_nxt   = r_rem;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_addr_nxt  = i_buf_vaddr;
               w_rem_nxt   = i_buf_size;
               w_state_nxt = (i_buf_size == '0) ? ST_DONE : ST_SPLIT;
            end
         end
         ST_SPLIT: begin
            if (w_issue) begin
               w_addr_nxt = r_addr + VADDR_BITS'(r_req_len);
               w_rem_nxt  = r_rem - SIZE_BITS'(r_req_len);
               if (r_req_last)
                  w_state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (w_cnt_nxt == '0)
               w_state_nxt = ST_DONE;
         end
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Split is taken from the position the request registers will describe, so
   // a request is visible the cycle after accept and back-to-back after a handshake.
   always_comb begin
      w_room       = LEN_BITS'(MAX_REQ_BYTES) - {1'b0, w_addr_nxt[LEN_BITS-2:0]};
      w_split_len  = (w_rem_nxt < SIZE_BITS'(w_room)) ? LEN_BITS'(w_rem_nxt) : w_room;
      w_split_last = (SIZE_BITS'(w_split_len) == w_rem_nxt);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_addr      <= '0;
         r_rem       <= '0;
         r_req_vaddr <= '0;
         r_req_len   <= '0;
         r_req_last  <= 1'b0;
         r_req_valid <= 1'b0;
         r_ready_en  <= 1'b0;
      end else begin
         r_addr     <= w_addr_nxt;
         r_rem      <= w_rem_nxt;
         r_ready_en <= 1'b1;
         if (w_state_nxt == ST_SPLIT && (!r_req_valid || w_issue)) begin
            r_req_valid <= w_below_nxt;
            r_req_vaddr <= w_addr_nxt;
            r_req_len   <= w_split_len;
            r_req_last  <= w_split_last;
         end else if (w_state_nxt != ST_SPLIT) begin
            r_req_valid <= 1'b0;
         end
      end
   end

   inflight_counter #(
      .LIMIT (MAX_OUTSTANDING)
   ) u_inflight (
      .i_clk             (i_clk),
      .i_rst             (i_rst),
      .i_inc             (w_issue),
      .i_dec             (i_cpl_valid),
      .o_count_nxt       (w_cnt_nxt),
      .o_below_limit_nxt (w_below_nxt),
      .o_err_underflow   (o_err_cpl)
   );

   assign o_buf_ready  = (r_state == ST_IDLE) && r_ready_en;
   assign o_req_vaddr  = r_req_vaddr;
   assign o_req_len    = r_req_len;
   assign o_req_last   = r_req_last;
   assign o_req_valid  = r_req_valid;
   assign o_done_valid = (r_state == ST_DONE);
   assign o_busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_buffer_walker.sv
// Bench for mem_buffer_walker: directed scenarios plus random descriptors,
// checked every cycle against a queue-based model of the expected requests.
module tb_mem_buffer_walker;

   localparam int MAXO = 2;
   localparam longint unsigned MASK48 = 64'h0000_FFFF_FFFF_FFFF;
   localparam int P_IDLE = 0, P_ACT = 1, P_DONE = 2;

   logic        clk = 1'b0;
   logic        i_rst = 1'b1;
   logic [47:0] i_buf_vaddr = '0;
   logic [27:0] i_buf_size = '0;
   logic        i_buf_valid = 1'b0;
   logic        o_buf_ready;
   logic [47:0] o_req_vaddr;
   logic [12:0] o_req_len;
   logic        o_req_last;
   logic        o_req_valid;
   logic        i_req_ready = 1'b0;
   logic        i_cpl_valid = 1'b0;
   logic        o_done_valid;
   logic        o_busy;
   logic        o_err_cpl;

   mem_buffer_walker #(.MAX_OUTSTANDING(MAXO)) dut (
      .i_clk(clk), .i_rst(i_rst),
      .i_buf_vaddr(i_buf_vaddr), .i_buf_size(i_buf_size),
      .i_buf_valid(i_buf_valid), .o_buf_ready(o_buf_ready),
      .o_req_vaddr(o_req_vaddr), .o_req_len(o_req_len),
      .o_req_last(o_req_last), .o_req_valid(o_req_valid),
      .i_req_ready(i_req_ready), .i_cpl_valid(i_cpl_valid),
      .o_done_valid(o_done_valid), .o_busy(o_busy), .o_err_cpl(o_err_cpl)
   );

   always #5 clk = ~clk;

   typedef struct {
      longint unsigned va;
      int              len;
      bit              last;
   } req_t;

   req_t q[$];
   int   m_phase = P_IDLE;
   int   m_out = 0;
   bit   m_err = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic void build(input longint unsigned va, input longint unsigned sz);
      longint unsigned a = va & MASK48;
      longint unsigned r = sz;
      q.delete();
      while (r > 0) begin
         longint unsigned room = 4096 - (a % 4096);
         longint unsigned l = (r < room) ? r : room;
         req_t e;
         e.va = a;
         e.len = int'(l);
         e.last = (l == r);
         q.push_back(e);
         a = (a + l) & MASK48;
         r = r - l;
      end
   endfunction

   function automatic bit exp_valid();
      return (m_phase == P_ACT) && (q.size() > 0) && (m_out < MAXO);
   endfunction

   task automatic check_outputs();
      bit ev = exp_valid();
      chk("buf_ready", 64'(o_buf_ready), 64'(m_phase == P_IDLE));
      chk("req_valid", 64'(o_req_valid), 64'(ev));
      chk("done_valid", 64'(o_done_valid), 64'(m_phase == P_DONE));
      chk("busy", 64'(o_busy), 64'(m_phase != P_IDLE));
      chk("err_cpl", 64'(o_err_cpl), 64'(m_err));
      if (ev) begin
         chk("req_vaddr", 64'(o_req_vaddr), q[0].va);
         chk("req_len", 64'(o_req_len), 64'(q[0].len));
         chk("req_last", 64'(o_req_last), 64'(q[0].last));
      end
   endtask

   // Inputs are applied just after a falling edge, the model advances across
   // the coming rising edge, and outputs are compared at the next falling edge.
   task automatic step(input bit rdy, input bit cpl, input bit bv,
                       input longint unsigned va, input longint unsigned sz);
      bit hs;
      i_req_ready = rdy;
      i_cpl_valid = cpl;
      i_buf_valid = bv;
      i_buf_vaddr = va[47:0];
      i_buf_size  = sz[27:0];
      hs = exp_valid() && rdy;
      if (hs) begin
         void'(q.pop_front());
         m_out++;
      end
      if (cpl) begin
         if (m_out > 0) m_out--;
         else m_err = 1'b1;
      end
      case (m_phase)
         P_IDLE: if (bv) begin
            build(va, sz);
            m_phase = (q.size() == 0) ? P_DONE : P_ACT;
         end
         P_ACT:  if (q.size() == 0 && m_out == 0) m_phase = P_DONE;
         default: m_phase = P_IDLE;
      endcase
      @(negedge clk);
      check_outputs();
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      i_buf_valid = 1'b0;
      i_req_ready = 1'b0;
      i_cpl_valid = 1'b0;
      @(negedge clk);
      chk("rst_buf_ready", 64'(o_buf_ready), 64'd0);
      chk("rst_req_valid", 64'(o_req_valid), 64'd0);
      chk("rst_req_last", 64'(o_req_last), 64'd0);
      chk("rst_done", 64'(o_done_valid), 64'd0);
      chk("rst_busy", 64'(o_busy), 64'd0);
      chk("rst_err", 64'(o_err_cpl), 64'd0);
      i_rst = 1'b0;
      q.delete();
      m_phase = P_IDLE;
      m_out = 0;
      m_err = 1'b0;
      @(negedge clk);
      chk("rst_release_ready", 64'(o_buf_ready), 64'd1);
   endtask

   task automatic run_buf(input longint unsigned va, input longint unsigned sz,
                          input int rdy_pct, input int cpl_pct, input bit stall);
      int cyc = 0;
      int stall_cnt = 0;
      int n_total;
      step(1'b0, 1'b0, 1'b1, va, sz);
      n_total = q.size();
      while (m_phase != P_IDLE && cyc < 400) begin
         bit rdy = ($urandom_range(99) < rdy_pct);
         bit cpl = (m_out > 0) && ($urandom_range(99) < cpl_pct);
         bit bv  = $urandom_range(1) == 1;
         if (stall && q.size() == n_total - 1 && stall_cnt < 5) begin
            rdy = 1'b0;
            stall_cnt++;
         end
         step(rdy, cpl, bv, {$urandom, $urandom}, 64'($urandom_range(0, 'h3000)));
         cyc++;
      end
      chk("buf_complete", 64'(m_phase), 64'(P_IDLE));
   endtask

   initial begin
      do_reset();

      run_buf(64'h1000, 64'h3000, 100, 30, 1'b0);
      run_buf(64'h1F00, 64'h300, 100, 50, 1'b0);
      run_buf(64'h5000, 64'h0, 100, 50, 1'b0);
      run_buf(64'h0, 64'h3000, 100, 40, 1'b1);
      run_buf(64'hFFFF_FFFF_FF80, 64'h200, 80, 50, 1'b0);

      // In-flight limit: two issue, valid drops, third issues with a same-cycle completion.
      step(1'b1, 1'b0, 1'b1, 64'h0, 64'h4000);
      repeat (4) step(1'b1, 1'b0, 1'b0, 64'h0, 64'h0);
      step(1'b1, 1'b1, 1'b0, 64'h0, 64'h0);
      step(1'b1, 1'b1, 1'b0, 64'h0, 64'h0);
      step(1'b1, 1'b0, 1'b0, 64'h0, 64'h0);
      for (int i = 0; i < 60 && m_phase != P_IDLE; i++)
         step(1'b1, m_out > 0, 1'b0, 64'h0, 64'h0);
      chk("limit_buf_complete", 64'(m_phase), 64'(P_IDLE));

      for (int n = 0; n < 40; n++) begin
         longint unsigned va = {$urandom, $urandom};
         longint unsigned sz = 64'($urandom_range(1, 'h2800));
         if ($urandom_range(3) == 0) va = (va & ~64'hFFF) | 64'($urandom_range('hF00, 'hFFF));
         if ($urandom_range(7) == 0) sz = 0;
         run_buf(va, sz, $urandom_range(40, 100), $urandom_range(20, 80), $urandom_range(3) == 0);
      end

      // Reset mid-split drops the buffer; a later completion is an underflow.
      step(1'b1, 1'b0, 1'b1, 64'h2000, 64'h4000);
      step(1'b1, 1'b0, 1'b0, 64'h0, 64'h0);
      do_reset();
      step(1'b0, 1'b1, 1'b0, 64'h0, 64'h0);
      repeat (3) step(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
      do_reset();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired @%0t", $time);
      $fatal(1);
   end

endmodule
